// File: rtl/pim_regbridge.sv
// Bridges an MPMC-style PIM port onto a simple single-cycle register bus.
// Write and read bursts are buffered in small FIFOs and replayed one word at a time.
module pim_regbridge #(
  parameter int C_DWIDTH       = 32,
  parameter int C_AWIDTH       = 6,
  parameter int C_WRFIFO_DEPTH = 16,
  parameter int C_RDFIFO_DEPTH = 16,
  parameter int C_AFULL_MARGIN = 2,
  parameter int C_INIT_CYCLES  = 8
) (
  input  logic                  MPMC_Clk,
  input  logic                  MPMC_Rst,
  input  logic [31:0]           PIM_Addr,
  input  logic                  PIM_AddrReq,
  input  logic                  PIM_RNW,
  input  logic [3:0]            PIM_Size,
  input  logic                  PIM_RdModWr,
  output logic                  PIM_AddrAck,
  output logic [C_DWIDTH-1:0]   PIM_RdFIFO_Data,
  output logic [3:0]            PIM_RdFIFO_RdWdAddr,
  output logic                  PIM_RdFIFO_Empty,
  input  logic                  PIM_RdFIFO_Pop,
  input  logic                  PIM_RdFIFO_Flush,
  output logic [1:0]            PIM_RdFIFO_Latency,
  input  logic [C_DWIDTH-1:0]   PIM_WrFIFO_Data,
  input  logic [C_DWIDTH/8-1:0] PIM_WrFIFO_BE,
  input  logic                  PIM_WrFIFO_Push,
  input  logic                  PIM_WrFIFO_Flush,
  output logic                  PIM_WrFIFO_Empty,
  output logic                  PIM_WrFIFO_AlmostFull,
  output logic                  PIM_InitDone,
  output logic [C_AWIDTH-1:0]   address,
  output logic                  write,
  output logic                  read,
  output logic [C_DWIDTH-1:0]   writedata,
  output logic [C_DWIDTH/8-1:0] byteenable,
  input  logic [C_DWIDTH-1:0]   readdata
);

  localparam int BW     = C_DWIDTH / 8;
  localparam int WR_PW  = $clog2(C_WRFIFO_DEPTH);
  localparam int WR_CW  = WR_PW + 1;
  localparam int RD_PW  = $clog2(C_RDFIFO_DEPTH);
  localparam int RD_CW  = RD_PW + 1;
  localparam int INIT_W = $clog2(C_INIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_ISSUE, RD_CAPTURE} state_t;

  state_t              state_q, state_d;
  logic [C_AWIDTH-1:0] addr_q, addr_d;
  logic [3:0]          beat_q, beat_d;
  logic [3:0]          last_q, last_d;
  logic                discard_q, discard_d;
  logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
  logic                init_done_q, init_done_d;

  logic [C_DWIDTH-1:0] wr_data_mem [C_WRFIFO_DEPTH];
  logic [BW-1:0]       wr_be_mem   [C_WRFIFO_DEPTH];
  logic [WR_PW-1:0]    wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
  logic [WR_CW-1:0]    wr_count_q, wr_count_d, wr_free, req_len_w;
  logic                wr_push, wr_pop, wr_full;

  logic [C_DWIDTH-1:0] rd_data_mem [C_RDFIFO_DEPTH];
  logic [3:0]          rd_idx_mem  [C_RDFIFO_DEPTH];
  logic [RD_PW-1:0]    rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
  logic [RD_CW-1:0]    rd_count_q, rd_count_d, rd_free, req_len_r;
  logic                rd_push, rd_push_ok, rd_pop, rd_full, rd_empty;

  logic [3:0]          size_last;
  logic                unused_ok;

  assign unused_ok = ^{PIM_RdModWr, PIM_Addr[31:C_AWIDTH+2], PIM_Addr[1:0]};

  // Burst length is carried as the index of the final beat.
  always_comb begin
    size_last = 4'd0;
    case (PIM_Size)
      4'd1:    size_last = 4'd3;
      4'd2:    size_last = 4'd7;
      4'd3:    size_last = 4'd15;
      default: size_last = 4'd0;
    endcase
  end

  assign req_len_w = WR_CW'(size_last) + WR_CW'(1);
  assign req_len_r = RD_CW'(size_last) + RD_CW'(1);

  assign wr_full               = (wr_count_q == WR_CW'(C_WRFIFO_DEPTH));
  assign wr_free               = WR_CW'(C_WRFIFO_DEPTH) - wr_count_q;
  assign wr_push               = PIM_WrFIFO_Push && !wr_full;
  assign PIM_WrFIFO_Empty      = (wr_count_q == '0);
  assign PIM_WrFIFO_AlmostFull = (wr_free <= WR_CW'(C_AFULL_MARGIN));

  assign rd_empty            = (rd_count_q == '0);
  assign rd_full             = (rd_count_q == RD_CW'(C_RDFIFO_DEPTH));
  assign rd_free             = RD_CW'(C_RDFIFO_DEPTH) - rd_count_q;
  assign rd_push_ok          = rd_push && !rd_full;
  assign rd_pop              = PIM_RdFIFO_Pop && !rd_empty;
  assign PIM_RdFIFO_Empty    = rd_empty;
  assign PIM_RdFIFO_Data     = rd_data_mem[rd_rptr_q];
  assign PIM_RdFIFO_RdWdAddr = rd_idx_mem[rd_rptr_q];
  assign PIM_RdFIFO_Latency  = 2'd0;
  assign PIM_InitDone        = init_done_q;

  always_comb begin
    init_cnt_d  = init_done_q ? init_cnt_q : init_cnt_q + INIT_W'(1);
    init_done_d = init_done_q || (init_cnt_q == INIT_W'(C_INIT_CYCLES - 1));
  end

  always_comb begin
    wr_wptr_d  = wr_wptr_q;
    wr_rptr_d  = wr_rptr_q;
    wr_count_d = wr_count_q;
    if (PIM_WrFIFO_Flush) begin
      wr_wptr_d  = '0;
      wr_rptr_d  = '0;
      wr_count_d = '0;
    end else begin
      if (wr_push) wr_wptr_d = wr_wptr_q + WR_PW'(1);
      if (wr_pop)  wr_rptr_d = wr_rptr_q + WR_PW'(1);
      wr_count_d = wr_count_q + WR_CW'(wr_push) - WR_CW'(wr_pop);
    end
  end

  always_comb begin
    rd_wptr_d  = rd_wptr_q;
    rd_rptr_d  = rd_rptr_q;
    rd_count_d = rd_count_q;
    if (PIM_RdFIFO_Flush) begin
      rd_wptr_d  = '0;
      rd_rptr_d  = '0;
      rd_count_d = '0;
    end else begin
      if (rd_push_ok) rd_wptr_d = rd_wptr_q + RD_PW'(1);
      if (rd_pop)     rd_rptr_d = rd_rptr_q + RD_PW'(1);
      rd_count_d = rd_count_q + RD_CW'(rd_push_ok) - RD_CW'(rd_pop);
    end
  end

  // Bus strobes are decoded from the state register so reset silences them at once.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    last_d      = last_q;
    discard_d   = discard_q;
    PIM_AddrAck = 1'b0;
    wr_pop      = 1'b0;
    rd_push     = 1'b0;
    write       = 1'b0;
    read        = 1'b0;
    address     = '0;
    writedata   = '0;
    byteenable  = '0;
    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (init_done_q && PIM_AddrReq) begin
          if ((!PIM_RNW && wr_count_q >= req_len_w) || (PIM_RNW && rd_free >= req_len_r)) begin
            PIM_AddrAck = 1'b1;
            state_d     = PIM_RNW ? RD_ISSUE : WR_BURST;
            addr_d      = PIM_Addr[C_AWIDTH+1:2];
            beat_d      = 4'd0;
            last_d      = size_last;
          end
        end
      end
      WR_BURST: begin
        if (PIM_WrFIFO_Flush) begin
          state_d = IDLE;
        end else begin
          wr_pop     = 1'b1;
          write      = |wr_be_mem[wr_rptr_q];
          address    = addr_q;
          writedata  = wr_data_mem[wr_rptr_q];
          byteenable = wr_be_mem[wr_rptr_q];
          addr_d     = addr_q + C_AWIDTH'(1);
          beat_d     = beat_q + 4'd1;
          if (beat_q == last_q) state_d = IDLE;
        end
      end
      RD_ISSUE: begin
        read      = 1'b1;
        address   = addr_q;
        discard_d = discard_q || PIM_RdFIFO_Flush;
        state_d   = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        rd_push = !discard_q && !PIM_RdFIFO_Flush;
        addr_d  = addr_q + C_AWIDTH'(1);
        beat_d  = beat_q + 4'd1;
        if (beat_q == last_q) begin
          state_d   = IDLE;
          discard_d = 1'b0;
        end else begin
          state_d   = RD_ISSUE;
          discard_d = discard_q || PIM_RdFIFO_Flush;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MPMC_Clk or posedge MPMC_Rst) begin
    if (MPMC_Rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      beat_q      <= '0;
      last_q      <= '0;
      discard_q   <= 1'b0;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      wr_wptr_q   <= '0;
      wr_rptr_q   <= '0;
      wr_count_q  <= '0;
      rd_wptr_q   <= '0;
      rd_rptr_q   <= '0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      discard_q   <= discard_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      wr_wptr_q   <= wr_wptr_d;
      wr_rptr_q   <= wr_rptr_d;
      wr_count_q  <= wr_count_d;
      rd_wptr_q   <= rd_wptr_d;
      rd_rptr_q   <= rd_rptr_d;
      rd_count_q  <= rd_count_d;
    end
  end

  // Storage arrays need no reset; emptiness is tracked by the pointers and counts.
  always_ff @(posedge MPMC_Clk) begin
    if (wr_push) begin
      wr_data_mem[wr_wptr_q] <= PIM_WrFIFO_Data;
      wr_be_mem[wr_wptr_q]   <= PIM_WrFIFO_BE;
    end
    if (rd_push_ok) begin
      rd_data_mem[rd_wptr_q] <= readdata;
      rd_idx_mem[rd_wptr_q]  <= beat_q;
    end
  end

endmodule

// File: tb/tb_pim_regbridge.sv
// Directed-random bench for pim_regbridge: a register-bus slave model and
// queue-based FIFO models predict every strobe and every read FIFO word.
module tb_pim_regbridge;

   logic        clk = 1'b0;
   logic        mpmcRst;
   logic [31:0] pimAddr;
   logic        addrReq, rnw, rdModWr;
   logic [3:0]  pimSize;
   logic        addrAck;
   logic [31:0] rdData;
   logic [3:0]  rdWdAddr;
   logic        rdEmpty, rdPop, rdFlush;
   logic [1:0]  rdLatency;
   logic [31:0] wrData;
   logic [3:0]  wrBe;
   logic        wrPush, wrFlush, wrEmpty, wrAfull, initDone;
   logic [5:0]  busAddr;
   logic        busWrite, busRead;
   logic [31:0] busWdata;
   logic [3:0]  busBe;
   logic [31:0] busRdata = '0;

   typedef struct {
      int          cyc;
      logic [5:0]  addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wrObs_t;

   wrObs_t      obsWr[$];
   logic [5:0]  obsRd[$];
   logic [35:0] wrModel[$];
   logic [35:0] rdModel[$];
   logic [31:0] regMem[64];
   int          cycleNo = 0;
   int          testCount = 0;
   int          failCount = 0;

   pim_regbridge dut (
      .MPMC_Clk(clk), .MPMC_Rst(mpmcRst),
      .PIM_Addr(pimAddr), .PIM_AddrReq(addrReq), .PIM_RNW(rnw), .PIM_Size(pimSize),
      .PIM_RdModWr(rdModWr), .PIM_AddrAck(addrAck),
      .PIM_RdFIFO_Data(rdData), .PIM_RdFIFO_RdWdAddr(rdWdAddr), .PIM_RdFIFO_Empty(rdEmpty),
      .PIM_RdFIFO_Pop(rdPop), .PIM_RdFIFO_Flush(rdFlush), .PIM_RdFIFO_Latency(rdLatency),
      .PIM_WrFIFO_Data(wrData), .PIM_WrFIFO_BE(wrBe), .PIM_WrFIFO_Push(wrPush),
      .PIM_WrFIFO_Flush(wrFlush), .PIM_WrFIFO_Empty(wrEmpty),
      .PIM_WrFIFO_AlmostFull(wrAfull), .PIM_InitDone(initDone),
      .address(busAddr), .write(busWrite), .read(busRead), .writedata(busWdata),
      .byteenable(busBe), .readdata(busRdata)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Register slave: returns the addressed word one cycle after a read strobe
   always @(posedge clk) begin
      if (busRead) busRdata <= regMem[busAddr];
   end

   // Bus monitor: records every strobe seen mid-cycle, away from the active edge
   always @(negedge clk) begin
      cycleNo++;
      if (!mpmcRst) begin
         if (busWrite) obsWr.push_back('{cycleNo, busAddr, busBe, busWdata});
         if (busRead) obsRd.push_back(busAddr);
      end
   end

   // Burst length rule from the size code
   function automatic int lenOf(input logic [3:0] code);
      case (code)
         4'd1: return 4;
         4'd2: return 8;
         4'd3: return 16;
         default: return 1;
      endcase
   endfunction

   // One comparison: counts it and reports any difference
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Pushes n random words into the write FIFO, mirroring them in the model
   task automatic pushWords(input int n, input bit allowZeroBe);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         wrPush = 1'b1;
         wrData = $urandom;
         if (allowZeroBe && $urandom_range(0, 3) == 0) wrBe = 4'h0;
         else wrBe = 4'($urandom_range(1, 15));
         if (wrModel.size() < 16) wrModel.push_back({wrBe, wrData});
      end
      @(posedge clk); #1;
      wrPush = 1'b0;
   endtask

   task automatic raiseReq(input logic [31:0] a, input logic isRead, input logic [3:0] code);
      @(posedge clk); #1;
      pimAddr = a;
      rnw     = isRead;
      pimSize = code;
      addrReq = 1'b1;
   endtask

   // Waits a bounded number of cycles for the ack, then checks it lasted one cycle
   task automatic waitAck(input string tag, input int budget);
      bit got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (addrAck === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput(tag, 64'(got), 64'd1);
      if (got) begin
         @(posedge clk); #1;
         @(negedge clk);
         checkOutput({tag, "_pulse"}, 64'(addrAck), 64'd0);
      end
   endtask

   task automatic releaseReq();
      @(posedge clk); #1;
      addrReq = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic isRead, input logic [3:0] code, input string tag);
      raiseReq(a, isRead, code);
      waitAck(tag, 20);
      releaseReq();
   endtask

   // Holds the request and confirms no ack appears for several cycles
   task automatic expectNoAck(input string tag);
      bit seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (addrAck === 1'b1) seen = 1'b1;
      end
      checkOutput(tag, 64'(seen), 64'd0);
   endtask

   task automatic expectWrites(input logic [5:0] start, input int len, input string tag);
      logic [35:0] w;
      logic [41:0] expQ[$];
      logic [41:0] o;
      repeat (len + 3) @(negedge clk);
      for (int i = 0; i < len; i++) begin
         if (wrModel.size() == 0) break;
         w = wrModel.pop_front();
         if (w[35:32] != 4'h0) expQ.push_back({6'((int'(start) + i) % 64), w[35:32], w[31:0]});
      end
      checkOutput({tag, "_count"}, 64'(obsWr.size()), 64'(expQ.size()));
      for (int i = 0; i < expQ.size() && i < obsWr.size(); i++) begin
         o = {obsWr[i].addr, obsWr[i].be, obsWr[i].data};
         checkOutput($sformatf("%s_beat%0d", tag, i), 64'(o), 64'(expQ[i]));
      end
      obsWr.delete();
   endtask

   task automatic expectReads(input logic [5:0] start, input int len, input string tag, input bit discard);
      logic [5:0] a;
      repeat (2 * len + 3) @(negedge clk);
      checkOutput({tag, "_count"}, 64'(obsRd.size()), 64'(len));
      for (int i = 0; i < len; i++) begin
         a = 6'((int'(start) + i) % 64);
         if (i < obsRd.size()) checkOutput($sformatf("%s_addr%0d", tag, i), 64'(obsRd[i]), 64'(a));
         if (!discard && rdModel.size() < 16) rdModel.push_back({4'(i), regMem[a]});
      end
      obsRd.delete();
   endtask

   task automatic popCheck(input int n, input string tag);
      logic [35:0] e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rdModel.size() == 0) begin
            checkOutput({tag, "_empty"}, 64'(rdEmpty), 64'd1);
         end else begin
            e = rdModel.pop_front();
            checkOutput($sformatf("%s_%0d", tag, i), 64'({rdEmpty, rdWdAddr, rdData}), 64'({1'b0, e}));
         end
         @(posedge clk); #1;
         rdPop = 1'b1;
         @(posedge clk); #1;
         rdPop = 1'b0;
      end
   endtask

   task automatic checkInitDone(input string tag);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 7) checkOutput({tag, "_at7"}, 64'(initDone), 64'd0);
         if (k == 8) checkOutput({tag, "_at8"}, 64'(initDone), 64'd1);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ack"}, 64'(addrAck), 64'd0);
      checkOutput({tag, "_write"}, 64'(busWrite), 64'd0);
      checkOutput({tag, "_read"}, 64'(busRead), 64'd0);
      checkOutput({tag, "_addr"}, 64'(busAddr), 64'd0);
      checkOutput({tag, "_wdata"}, 64'(busWdata), 64'd0);
      checkOutput({tag, "_be"}, 64'(busBe), 64'd0);
      checkOutput({tag, "_rdempty"}, 64'(rdEmpty), 64'd1);
      checkOutput({tag, "_wrempty"}, 64'(wrEmpty), 64'd1);
      checkOutput({tag, "_afull"}, 64'(wrAfull), 64'd0);
      checkOutput({tag, "_initdone"}, 64'(initDone), 64'd0);
   endtask

   // Directed sequence with randomized data, addresses and burst sizes
   initial begin
      logic [31:0] a;
      logic [3:0]  code;
      mpmcRst = 1'b1;
      pimAddr = '0; addrReq = 1'b0; rnw = 1'b0; pimSize = '0; rdModWr = 1'b0;
      rdPop = 1'b0; rdFlush = 1'b0; wrData = '0; wrBe = '0; wrPush = 1'b0; wrFlush = 1'b0;
      for (int i = 0; i < 64; i++) regMem[i] = $urandom;

      repeat (3) @(negedge clk);
      checkResetOutputs("rst");
      checkOutput("rst_latency", 64'(rdLatency), 64'd0);
      @(posedge clk); #1;
      mpmcRst = 1'b0;
      checkInitDone("init");

      // Single write of a known word to byte address 0x14
      @(posedge clk); #1;
      wrPush = 1'b1; wrData = 32'hDEADBEEF; wrBe = 4'hF;
      @(posedge clk); #1;
      wrPush = 1'b0;
      @(negedge clk);
      checkOutput("single_wrempty_before", 64'(wrEmpty), 64'd0);
      raiseReq(32'h14, 1'b0, 4'd0);
      waitAck("single_wr_ack", 20);
      checkOutput("single_wr_strobe", 64'({busWrite, busAddr, busBe, busWdata}), 64'({1'b1, 6'd5, 4'hF, 32'hDEADBEEF}));
      releaseReq();
      @(negedge clk);
      checkOutput("single_wrempty_after", 64'(wrEmpty), 64'd1);
      obsWr.delete();

      // Random write bursts, some words with all byte lanes disabled
      for (int t = 0; t < 3; t++) begin
         code = 4'($urandom_range(0, 5));
         a = $urandom;
         pushWords(lenOf(code), 1'b1);
         applyStimulus(a, 1'b0, code, "rndwr_ack");
         expectWrites(a[7:2], lenOf(code), "rndwr");
      end

      // Four-beat write held off until the fourth word arrives
      a = $urandom;
      pushWords(3, 1'b0);
      raiseReq(a, 1'b0, 4'd1);
      expectNoAck("wr_hold_ack");
      pushWords(1, 1'b0);
      waitAck("wr_ack_after_4th", 1);
      releaseReq();
      repeat (8) @(negedge clk);
      checkOutput("wr_b2b", 64'((obsWr.size() == 4) ? obsWr[3].cyc - obsWr[0].cyc : -1), 64'd3);
      expectWrites(a[7:2], 4, "wr4");

      // Almost-full threshold, then overfill so the extra push is dropped
      pushWords(13, 1'b0);
      @(negedge clk);
      checkOutput("afull_13", 64'(wrAfull), 64'd0);
      pushWords(1, 1'b0);
      @(negedge clk);
      checkOutput("afull_14", 64'(wrAfull), 64'd1);
      pushWords(3, 1'b0);
      a = $urandom;
      applyStimulus(a, 1'b0, 4'd3, "full_wr_ack");
      expectWrites(a[7:2], 16, "full_wr");
      checkOutput("full_wr_empty", 64'(wrEmpty), 64'd1);

      // Write flush on beat index 2 of an 8-beat burst aborts it
      pushWords(8, 1'b0);
      raiseReq($urandom, 1'b0, 4'd2);
      waitAck("flush_wr_ack", 20);
      @(posedge clk); #1;
      addrReq = 1'b0;
      @(posedge clk); #1;
      wrFlush = 1'b1;
      @(negedge clk);
      checkOutput("flush_wr_nostrobe", 64'(busWrite), 64'd0);
      @(posedge clk); #1;
      wrFlush = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("flush_wr_strobes", 64'(obsWr.size()), 64'd2);
      checkOutput("flush_wr_empty", 64'(wrEmpty), 64'd1);
      obsWr.delete();
      wrModel.delete();

      // Four-beat read wrapping past the top of the register space
      applyStimulus(32'hF8, 1'b1, 4'd1, "rd4_ack");
      expectReads(6'd62, 4, "rd4", 1'b0);
      popCheck(4, "rd4_pop");
      @(negedge clk);
      checkOutput("rd4_empty", 64'(rdEmpty), 64'd1);

      // Fill the read FIFO to 14 words, then a 4-beat read must wait for space
      for (int t = 0; t < 4; t++) begin
         code = (t == 0) ? 4'd2 : (t == 1) ? 4'd1 : 4'd0;
         a = $urandom;
         applyStimulus(a, 1'b1, code, "fill_ack");
         expectReads(a[7:2], lenOf(code), "fill", 1'b0);
      end
      a = $urandom;
      raiseReq(a, 1'b1, 4'd1);
      expectNoAck("rd_hold_ack");
      popCheck(2, "rd_hold_pop");
      waitAck("rd_ack_after_pop", 4);
      releaseReq();
      expectReads(a[7:2], 4, "rd_after_pop", 1'b0);
      popCheck(16, "rd_drain");
      @(negedge clk);
      checkOutput("rd_drain_empty", 64'(rdEmpty), 64'd1);

      // Random reads including an out-of-range size code
      for (int t = 0; t < 2; t++) begin
         code = (t == 0) ? 4'd9 : 4'($urandom_range(1, 3));
         a = $urandom;
         applyStimulus(a, 1'b1, code, "rndrd_ack");
         expectReads(a[7:2], lenOf(code), "rndrd", 1'b0);
         popCheck(lenOf(code), "rndrd_pop");
      end

      // Read flush mid-burst: all beats still issued, all data discarded
      a = $urandom;
      applyStimulus(a, 1'b1, 4'd2, "rdflush_ack");
      repeat (3) @(posedge clk);
      #1 rdFlush = 1'b1;
      @(posedge clk); #1;
      rdFlush = 1'b0;
      expectReads(a[7:2], 8, "rdflush", 1'b1);
      @(negedge clk);
      checkOutput("rdflush_empty", 64'(rdEmpty), 64'd1);
      a = $urandom;
      applyStimulus(a, 1'b1, 4'd0, "post_flush_ack");
      expectReads(a[7:2], 1, "post_flush", 1'b0);
      popCheck(1, "post_flush_pop");

      // Reset in the middle of a 16-beat read
      applyStimulus($urandom, 1'b1, 4'd3, "rstmid_ack");
      repeat (3) @(posedge clk);
      #3 mpmcRst = 1'b1;
      #1 checkResetOutputs("rstmid");
      repeat (2) @(posedge clk);
      #1 mpmcRst = 1'b0;
      obsRd.delete();
      rdModel.delete();
      checkInitDone("reinit");
      repeat (4) @(negedge clk);
      checkOutput("rstmid_no_reads", 64'(obsRd.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/pim_regbridge.md
PIM_REGBRIDGE -- requirements
Module: pim_regbridge

Interface
REQ-001 SHALL have parameters: C_DWIDTH, 32, data width of PIM FIFOs and register bus; C_AWIDTH, 6, register word-address width; C_WRFIFO_DEPTH, 16, write FIFO words, power of 2, at least 16; C_RDFIFO_DEPTH, 16, read FIFO words, power of 2, at least 16; C_AFULL_MARGIN, 2, free-slot threshold for AlmostFull; C_INIT_CYCLES, 8, reset-to-InitDone delay.
REQ-002 SHALL have one clock and one reset: MPMC_Clk in 1, the sole clock; MPMC_Rst in 1, reset, asynchronous, active-high.
REQ-003 SHALL have PIM address ports: PIM_Addr in 32, byte address; PIM_AddrReq in 1, request; PIM_RNW in 1, 1=read; PIM_Size in 4, burst code; PIM_RdModWr in 1, ignored; PIM_AddrAck out 1, accept pulse.
REQ-004 SHALL have PIM read ports: PIM_RdFIFO_Data out C_DWIDTH, head word; PIM_RdFIFO_RdWdAddr out 4, burst index of head word; PIM_RdFIFO_Empty out 1; PIM_RdFIFO_Pop in 1; PIM_RdFIFO_Flush in 1; PIM_RdFIFO_Latency out 2, constant 0.
REQ-005 SHALL have PIM write ports: PIM_WrFIFO_Data in C_DWIDTH; PIM_WrFIFO_BE in C_DWIDTH/8; PIM_WrFIFO_Push in 1; PIM_WrFIFO_Flush in 1; PIM_WrFIFO_Empty out 1; PIM_WrFIFO_AlmostFull out 1; PIM_InitDone out 1.
REQ-006 SHALL have register-bus ports: address out C_AWIDTH; write out 1, write strobe; read out 1, read strobe; writedata out C_DWIDTH; byteenable out C_DWIDTH/8; readdata in C_DWIDTH, valid one cycle after read.

Function
REQ-007 SHALL decode burst length L from PIM_Size: 0->1, 1->4, 2->8, 3->16, and any other code->1.
REQ-008 SHALL form the start word address as PIM_Addr[C_AWIDTH+1:2], incrementing by 1 per beat and wrapping modulo 2^C_AWIDTH.
REQ-009 SHALL implement the FSM states IDLE, WR_BURST, RD_ISSUE, RD_CAPTURE.
REQ-010 SHALL, in IDLE with InitDone=1 and AddrReq=1, pulse AddrAck for exactly 1 cycle and leave IDLE that cycle: for a write only when the write FIFO count is at least L, going to WR_BURST; for a read only when read FIFO free slots are at least L, going to RD_ISSUE. Otherwise it SHALL hold off the ack.
REQ-011 SHALL, in WR_BURST, pop one write-FIFO word per cycle and assert write with that word's data and BE plus the current address, for L consecutive cycles, then return to IDLE. A word whose BE is all zeros SHALL still consume a beat but keep write=0.
REQ-012 SHALL, in RD_ISSUE, assert read with the current address for one cycle and then go to RD_CAPTURE. RD_CAPTURE SHALL push readdata with its beat index into the read FIFO, then go to RD_ISSUE if beats remain, else IDLE, giving 2 cycles per read beat.
REQ-013 SHALL present the read FIFO head combinationally on PIM_RdFIFO_Data/RdWdAddr, with Pop advancing it on the next edge (latency 0).
REQ-014 SHALL ignore Pop while empty; a Push while full SHALL be dropped with FIFO state unchanged.
REQ-015 SHALL clear the write FIFO on WrFIFO_Flush. Flush beats a simultaneous push, and flush during WR_BURST SHALL abort the burst to IDLE with no further write strobes.
REQ-016 SHALL clear the read FIFO on RdFIFO_Flush. Flush beats a simultaneous capture push, and during a read burst the remaining beats SHALL still be issued but their data discarded until the burst ends.
REQ-017 SHALL assert WrFIFO_AlmostFull when write FIFO free slots are at most C_AFULL_MARGIN, and WrFIFO_Empty when count is 0.
REQ-018 SHALL allow simultaneous Push and internal pop on the same FIFO in one cycle, leaving count unchanged.
REQ-019 SHALL drive write, read and AddrAck low in every state not listed above.

Reset
REQ-020 SHALL, while MPMC_Rst=1, force: FSM=IDLE, both FIFOs empty, AddrAck=0, write=0, read=0, address=0, writedata=0, byteenable=0, RdFIFO_Empty=1, WrFIFO_Empty=1, AlmostFull=0, InitDone=0.
REQ-021 SHALL raise InitDone C_INIT_CYCLES cycles after MPMC_Rst deasserts and keep it high until the next reset.
REQ-022 SHALL abandon any burst in progress on reset mid-operation, with no strobe asserted after reset assertion.

Verification
REQ-023 Single write: push 0xDEADBEEF with BE=0xF, then AddrReq with Addr=0x14, RNW=0, Size=0 -> AddrAck 1 cycle; next cycle write=1, address=5, writedata=0xDEADBEEF; WrFIFO_Empty=1 after.
REQ-024 4-word read at Addr=0xF8 (word 62) -> reads at addresses 62,63,0,1; read FIFO holds 4 words with RdWdAddr 0..3; Pop×4 -> Empty=1.
REQ-025 Write with Size=1 and only 3 words pushed -> no AddrAck; 4th push -> AddrAck next eligible cycle and 4 back-to-back write strobes.
REQ-026 Read FIFO holding 14 of 16 words, then read with Size=1 -> ack withheld; Pop×2 -> ack issued.
REQ-027 WrFIFO_Flush on beat 2 of an 8-beat write -> exactly 2 write strobes, FSM returns to IDLE, WrFIFO_Empty=1.
REQ-028 MPMC_Rst asserted mid read burst -> all outputs take reset values immediately; InitDone returns high 8 cycles after release.
